decode_stage: RTL and testbench

- Instruction-decode stage of the 5-stage RV32I pipeline. Sits between IF/ID and EX, and drives the register-file read addresses.
- Decodes the IF/ID instruction, builds the immediate, and samples register-file read data in the same cycle.
- Detects load-use hazards and owns the ID/EX pipeline register, including bubble insertion, flush on branch mispredict and hold on EX backpressure.

---
 rtl/decode_pkg.sv | 77 +++++++
 rtl/decode_stage_imm_gen.sv | 29 ++
 rtl/decode_stage.sv | 200 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, ALU operations,
// the ID/EX pipeline bundle and small decode helpers.
package decode_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        SLL   = 4'd2,
        SLT   = 4'd3,
        SLTU  = 4'd4,
        XOR   = 4'd5,
        SRL   = 4'd6,
        SRA   = 4'd7,
        OR    = 4'd8,
        AND   = 4'd9,
        PASSB = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        alu_op_t     alu_op;
        logic        alusrc;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        pred_taken;
        logic        illegal;
    } id_ex_t;

    // Register-register and register-immediate ALU ops share the funct3 map;
    // 'alt' selects SUB/SRA (instr[30]) where that is meaningful.
    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? SUB : ADD;
            3'b001:  op = SLL;
            3'b010:  op = SLT;
            3'b011:  op = SLTU;
            3'b100:  op = XOR;
            3'b101:  op = alt ? SRA : SRL;
            3'b110:  op = OR;
            default: op = AND;
        endcase
        return op;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode == OP) || (opcode == OP_IMM) || (opcode == LOAD) ||
               (opcode == STORE) || (opcode == BRANCH) || (opcode == JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP) || (opcode == STORE) || (opcode == BRANCH);
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: picks the I/S/B/U/J format from the
// opcode and sign-extends from instr[31]. R-type and unknown opcodes give 0.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [6:0] opcode;

    assign opcode = instr[6:0];

    // Format selection by opcode
    always_comb begin
        imm = '0;
        case (opcode)
            OP_IMM, LOAD, JALR: imm = {{20{instr[31]}}, instr[31:20]};
            STORE:              imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH:             imm = {{19{instr[31]}}, instr[31], instr[7],
                                       instr[30:25], instr[11:8], 1'b0};
            LUI, AUIPC:         imm = {instr[31:12], 12'b0};
            JAL:                imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                       instr[20], instr[30:21], 1'b0};
            default:            imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: decodes the IF/ID word, reads the register
// file, detects load-use hazards and owns the ID/EX pipeline register.
module decode_stage
    import decode_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    input  logic            if_pred_taken,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ex_memread,
    input  logic [4:0]      ex_rd,
    input  logic            ex_hold,
    input  logic            flush,
    output logic            stall_out,
    output logic            id_valid,
    output logic [31:0]     id_pc,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data,
    output logic [31:0]     id_imm,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [2:0]      id_funct3,
    output logic [3:0]      id_alu_op,
    output logic            id_alusrc,
    output logic            id_regwrite,
    output logic            id_memread,
    output logic            id_memwrite,
    output logic            id_branch,
    output logic            id_jal,
    output logic            id_jalr,
    output logic            id_pred_taken,
    output logic            id_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        legal;
    logic        hazard;
    id_ex_t      dec;
    id_ex_t      id_ex;

    assign opcode   = if_instr[6:0];
    assign funct3   = if_instr[14:12];
    assign funct7   = if_instr[31:25];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    imm_gen u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    // A load in EX whose destination feeds a source register actually read here
    assign hazard = if_valid && ex_memread && (ex_rd != 5'd0) &&
                    ((uses_rs1(opcode) && (ex_rd == rs1_addr)) ||
                     (uses_rs2(opcode) && (ex_rd == rs2_addr)));

    // Flush kills the ID instruction, so a stall would only hold a dead slot
    assign stall_out = rst && !flush && (ex_hold || hazard);

    // Decode the IF/ID word into a full ID/EX bundle
    always_comb begin
        legal            = 1'b1;
        dec              = '0;
        dec.valid        = if_valid;
        dec.pc           = if_pc;
        dec.rs1_data     = rs1_data;
        dec.rs2_data     = rs2_data;
        dec.imm          = imm;
        dec.rs1          = rs1_addr;
        dec.rs2          = rs2_addr;
        dec.rd           = if_instr[11:7];
        dec.funct3       = funct3;
        dec.alu_op       = ADD;
        dec.pred_taken   = if_pred_taken;
        case (opcode)
            OP: begin
                dec.regwrite = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec.alu_op = alu_from_funct3(funct3, 1'b0);
                end else if ((funct7 == 7'b0100000) &&
                             ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
                    dec.alu_op = alu_from_funct3(funct3, 1'b1);
                end else begin
                    legal = 1'b0;
                end
            end
            OP_IMM: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.alu_op   = alu_from_funct3(funct3, (funct3 == 3'b101) && if_instr[30]);
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end
            end
            LOAD: begin
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.alusrc   = 1'b1;
                legal        = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            STORE: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                legal        = !funct3[2] && (funct3 != 3'b011);
            end
            BRANCH: begin
                dec.branch = 1'b1;
                dec.alu_op = SUB;
                legal      = (funct3[2:1] != 2'b01);
            end
            JAL: begin
                dec.jal      = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            JALR: begin
                dec.jalr     = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                legal        = (funct3 == 3'b000);
            end
            LUI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.alu_op   = PASSB;
            end
            AUIPC: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.illegal  = 1'b1;
            dec.alu_op   = ADD;
            dec.alusrc   = 1'b0;
            dec.regwrite = 1'b0;
            dec.memread  = 1'b0;
            dec.memwrite = 1'b0;
            dec.branch   = 1'b0;
            dec.jal      = 1'b0;
            dec.jalr     = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.regwrite = 1'b0;
        end
    end

    // ID/EX register: reset, then flush, hold, bubble, load in that priority
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_ex    <= '0;
            id_ex.pc <= RESET_PC;
        end else if (flush) begin
            id_ex <= '0;
        end else if (ex_hold) begin
            id_ex <= id_ex;
        end else if (!if_valid || hazard) begin
            id_ex <= '0;
        end else begin
            id_ex <= dec;
        end
    end

    assign id_valid      = id_ex.valid;
    assign id_pc         = id_ex.pc;
    assign id_rs1_data   = id_ex.rs1_data;
    assign id_rs2_data   = id_ex.rs2_data;
    assign id_imm        = id_ex.imm;
    assign id_rs1        = id_ex.rs1;
    assign id_rs2        = id_ex.rs2;
    assign id_rd         = id_ex.rd;
    assign id_funct3     = id_ex.funct3;
    assign id_alu_op     = id_ex.alu_op;
    assign id_alusrc     = id_ex.alusrc;
    assign id_regwrite   = id_ex.regwrite;
    assign id_memread    = id_ex.memread;
    assign id_memwrite   = id_ex.memwrite;
    assign id_branch     = id_ex.branch;
    assign id_jal        = id_ex.jal;
    assign id_jalr       = id_ex.jalr;
    assign id_pred_taken = id_ex.pred_taken;
    assign id_illegal    = id_ex.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vectors with literal expectations plus
// an instruction-level reference model compared every cycle.
module tb_decode_stage;
    import decode_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    localparam logic [31:0] I_ADDI   = 32'hFFF08293; // addi x5,x1,-1
    localparam logic [31:0] I_ADD    = 32'h00218233; // add  x4,x3,x2
    localparam logic [31:0] I_LUI    = 32'h123451B7; // lui  x3,0x12345
    localparam logic [31:0] I_BEQ    = 32'hFE208CE3; // beq  x1,x2,-8
    localparam logic [31:0] I_SW     = 32'h0020A623; // sw   x2,12(x1)
    localparam logic [31:0] I_ADDIX0 = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_JALX0  = 32'h0080006F; // jal  x0,8
    localparam logic [31:0] I_BADOPC = 32'h0000007F;
    localparam logic [31:0] I_BADOP  = 32'h40209233; // funct7=0100000 with sll

    logic        clk = 1'b0;
    logic        rst, if_valid, if_pred_taken, ex_memread, ex_hold, flush;
    logic [31:0] if_instr, if_pc, rs1_data, rs2_data;
    logic [4:0]  ex_rd, rs1_addr, rs2_addr;
    logic        stall_out, id_valid, id_alusrc, id_regwrite, id_memread, id_memwrite;
    logic        id_branch, id_jal, id_jalr, id_pred_taken, id_illegal;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [3:0]  id_alu_op;

    logic [31:0] regs [32];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic        model_ok     = 1'b0;
    id_ex_t      exp_q;

    always #5 clk = ~clk;

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_hold(ex_hold), .flush(flush), .stall_out(stall_out), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_alu_op(id_alu_op), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_jal(id_jal), .id_jalr(id_jalr), .id_pred_taken(id_pred_taken),
        .id_illegal(id_illegal)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-set rules, one instruction at a time
    function automatic id_ex_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                            input logic pred);
        id_ex_t      e = '0;
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        logic [31:0] sh20, sh19, sh11;
        logic        ok, writes;
        alu_op_t     base [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
        sh20 = $signed(ins) >>> 20;
        sh19 = $signed(ins) >>> 19;
        sh11 = $signed(ins) >>> 11;
        e.valid = 1'b1;
        e.pc = pc;
        e.pred_taken = pred;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd = ins[11:7];
        e.funct3 = f3;
        e.rs1_data = regs[ins[19:15]];
        e.rs2_data = regs[ins[24:20]];
        if (opc == OP_IMM || opc == LOAD || opc == JALR) e.imm = sh20;
        else if (opc == STORE) e.imm = (sh20 & ~32'h1F) | {27'b0, ins[11:7]};
        else if (opc == BRANCH) e.imm = (sh19 & 32'hFFFFF000) | ({31'b0, ins[7]} << 11) |
                                        ({26'b0, ins[30:25]} << 5) | ({28'b0, ins[11:8]} << 1);
        else if (opc == JAL) e.imm = (sh11 & 32'hFFF00000) | ({24'b0, ins[19:12]} << 12) |
                                     ({31'b0, ins[20]} << 11) | ({22'b0, ins[30:21]} << 1);
        else if (opc == LUI || opc == AUIPC) e.imm = ins & 32'hFFFFF000;
        else e.imm = 32'h0;
        case (opc)
            OP:     ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            OP_IMM: ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                         (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            LOAD:   ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            STORE:  ok = f3 <= 3'd2;
            BRANCH: ok = !(f3 inside {3'd2, 3'd3});
            JALR:   ok = f3 == 3'd0;
            JAL, LUI, AUIPC: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        writes = opc inside {OP, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC};
        e.illegal  = !ok;
        e.regwrite = ok && writes && (ins[11:7] != 5'd0);
        e.memread  = ok && opc == LOAD;
        e.memwrite = ok && opc == STORE;
        e.branch   = ok && opc == BRANCH;
        e.jal      = ok && opc == JAL;
        e.jalr     = ok && opc == JALR;
        e.alusrc   = ok && opc != OP && opc != BRANCH;
        e.alu_op   = ADD;
        if (ok && (opc == OP || opc == OP_IMM)) begin
            e.alu_op = base[f3];
            if (f7 == 7'h20 && f3 == 3'd5) e.alu_op = SRA;
            if (opc == OP && f7 == 7'h20 && f3 == 3'd0) e.alu_op = SUB;
        end else if (ok && opc == BRANCH) begin
            e.alu_op = SUB;
        end else if (ok && opc == LUI) begin
            e.alu_op = PASSB;
        end
        return e;
    endfunction

    function automatic logic model_hazard();
        logic [6:0] opc = if_instr[6:0];
        logic u1 = opc inside {OP, OP_IMM, LOAD, STORE, BRANCH, JALR};
        logic u2 = opc inside {OP, STORE, BRANCH};
        return if_valid && ex_memread && ex_rd != 5'd0 &&
               ((u1 && ex_rd == if_instr[19:15]) || (u2 && ex_rd == if_instr[24:20]));
    endfunction

    // Model of the ID/EX register, advanced on each rising edge
    always @(posedge clk) begin
        if (!rst) begin
            exp_q    = '0;
            exp_q.pc = RST_PC;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (flush) exp_q = '0;
            else if (ex_hold) exp_q = exp_q;
            else if (!if_valid || model_hazard()) exp_q = '0;
            else exp_q = model_decode(if_instr, if_pc, if_pred_taken);
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (model_ok) begin
            check_output("rs1_addr", 32'(rs1_addr), 32'(if_instr[19:15]));
            check_output("rs2_addr", 32'(rs2_addr), 32'(if_instr[24:20]));
            check_output("stall_out", 32'(stall_out),
                         32'(rst && !flush && (ex_hold || model_hazard())));
            check_output("id_valid", 32'(id_valid), 32'(exp_q.valid));
            check_output("id_pc", id_pc, exp_q.pc);
            check_output("id_rs1_data", id_rs1_data, exp_q.rs1_data);
            check_output("id_rs2_data", id_rs2_data, exp_q.rs2_data);
            check_output("id_imm", id_imm, exp_q.imm);
            check_output("id_rs1", 32'(id_rs1), 32'(exp_q.rs1));
            check_output("id_rs2", 32'(id_rs2), 32'(exp_q.rs2));
            check_output("id_rd", 32'(id_rd), 32'(exp_q.rd));
            check_output("id_funct3", 32'(id_funct3), 32'(exp_q.funct3));
            check_output("id_alu_op", 32'(id_alu_op), 32'(exp_q.alu_op));
            check_output("ctrl", 32'({id_alusrc, id_regwrite, id_memread, id_memwrite,
                                      id_branch, id_jal, id_jalr, id_pred_taken, id_illegal}),
                         32'({exp_q.alusrc, exp_q.regwrite, exp_q.memread, exp_q.memwrite,
                              exp_q.branch, exp_q.jal, exp_q.jalr, exp_q.pred_taken,
                              exp_q.illegal}));
        end
    end

    task automatic apply_stimulus(input logic r, input logic v, input logic [31:0] ins,
                                  input logic [31:0] pc, input logic pred, input logic mr,
                                  input logic [4:0] erd, input logic hold, input logic fl);
        rst = r; if_valid = v; if_instr = ins; if_pc = pc; if_pred_taken = pred;
        ex_memread = mr; ex_rd = erd; ex_hold = hold; flush = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pool [10] = '{I_ADDI, I_ADD, I_LUI, I_BEQ, I_SW, I_ADDIX0, I_JALX0,
                              I_BADOPC, I_BADOP, 32'h0030A183};

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
        regs[0] = 32'h0;
        regs[1] = 32'd7;
        apply_stimulus(0, 1, I_ADDI, 32'h0, 0, 0, 0, 1, 0);
        @(posedge clk); #1;

        // Reset: outputs cleared and stall suppressed even with ex_hold high
        apply_stimulus(0, 1, I_ADDI, 32'h0, 0, 0, 0, 1, 0);
        check_output("lit_rst_stall", 32'(stall_out), 32'd0);
        step();
        check_output("lit_rst_valid", 32'(id_valid), 32'd0);
        check_output("lit_rst_pc", id_pc, RST_PC);
        step();

        // addi x5,x1,-1 with x1 = 7
        apply_stimulus(1, 1, I_ADDI, 32'h200, 0, 0, 0, 0, 0);
        step();
        check_output("lit_addi_valid", 32'(id_valid), 32'd1);
        check_output("lit_addi_imm", id_imm, 32'hFFFFFFFF);
        check_output("lit_addi_rd", 32'(id_rd), 32'd5);
        check_output("lit_addi_alusrc", 32'(id_alusrc), 32'd1);
        check_output("lit_addi_regwrite", 32'(id_regwrite), 32'd1);
        check_output("lit_addi_rs1data", id_rs1_data, 32'd7);

        // Load-use: one bubble, then the add issues
        apply_stimulus(1, 1, I_ADD, 32'h204, 0, 1, 5'd3, 0, 0);
        check_output("lit_lu_stall", 32'(stall_out), 32'd1);
        step();
        check_output("lit_lu_bubble", 32'(id_valid), 32'd0);
        apply_stimulus(1, 1, I_ADD, 32'h204, 0, 0, 5'd3, 0, 0);
        check_output("lit_lu_release", 32'(stall_out), 32'd0);
        step();
        check_output("lit_add_valid", 32'(id_valid), 32'd1);
        check_output("lit_add_rd", 32'(id_rd), 32'd4);
        check_output("lit_add_rs1data", id_rs1_data, 32'hA303_0303);

        // LUI uses no register, so no stall despite rs2 field == ex_rd
        apply_stimulus(1, 1, I_LUI, 32'h208, 0, 1, 5'd3, 0, 0);
        check_output("lit_lui_stall", 32'(stall_out), 32'd0);
        step();
        check_output("lit_lui_imm", id_imm, 32'h12345000);
        check_output("lit_lui_aluop", 32'(id_alu_op), 32'd10);

        // Flush beats hold
        apply_stimulus(1, 1, I_ADDI, 32'h20C, 0, 0, 0, 1, 1);
        check_output("lit_flush_stall", 32'(stall_out), 32'd0);
        step();
        check_output("lit_flush_valid", 32'(id_valid), 32'd0);

        // Hold keeps ID/EX
        apply_stimulus(1, 1, I_ADDI, 32'h210, 0, 0, 0, 0, 0);
        step();
        apply_stimulus(1, 1, I_BEQ, 32'h214, 1, 0, 0, 1, 0);
        check_output("lit_hold_stall", 32'(stall_out), 32'd1);
        step();
        check_output("lit_hold_pc", id_pc, 32'h210);

        // beq x1,x2,-8 with prediction taken
        apply_stimulus(1, 1, I_BEQ, 32'h214, 1, 0, 0, 0, 0);
        step();
        check_output("lit_beq_imm", id_imm, 32'hFFFFFFF8);
        check_output("lit_beq_branch", 32'(id_branch), 32'd1);
        check_output("lit_beq_regwrite", 32'(id_regwrite), 32'd0);
        check_output("lit_beq_pred", 32'(id_pred_taken), 32'd1);

        // Store reading rs2 from a pending load
        apply_stimulus(1, 1, I_SW, 32'h218, 0, 1, 5'd2, 0, 0);
        check_output("lit_sw_stall", 32'(stall_out), 32'd1);
        step();
        apply_stimulus(1, 1, I_SW, 32'h218, 0, 0, 5'd2, 0, 0);
        step();
        check_output("lit_sw_imm", id_imm, 32'd12);
        check_output("lit_sw_memwrite", 32'(id_memwrite), 32'd1);

        // A load to x0 never causes a stall
        apply_stimulus(1, 1, I_ADDIX0, 32'h21C, 0, 1, 5'd0, 0, 0);
        check_output("lit_x0_stall", 32'(stall_out), 32'd0);
        step();

        // jal x0 does not write
        apply_stimulus(1, 1, I_JALX0, 32'h220, 0, 0, 0, 0, 0);
        step();
        check_output("lit_jal_imm", id_imm, 32'd8);
        check_output("lit_jal_regwrite", 32'(id_regwrite), 32'd0);

        // Illegal opcode and illegal funct7
        apply_stimulus(1, 1, I_BADOPC, 32'h224, 0, 0, 0, 0, 0);
        step();
        check_output("lit_ill_flag", 32'(id_illegal), 32'd1);
        check_output("lit_ill_valid", 32'(id_valid), 32'd1);
        apply_stimulus(1, 1, I_BADOP, 32'h228, 0, 0, 0, 0, 0);
        step();
        check_output("lit_illop_flag", 32'(id_illegal), 32'd1);
        check_output("lit_illop_regwrite", 32'(id_regwrite), 32'd0);

        // Invalid slot never stalls
        apply_stimulus(1, 0, I_ADD, 32'h22C, 0, 1, 5'd3, 0, 0);
        check_output("lit_inv_stall", 32'(stall_out), 32'd0);
        step();

        // Reset in the middle of a stall
        apply_stimulus(1, 1, I_ADD, 32'h230, 0, 1, 5'd3, 1, 0);
        check_output("lit_midstall_stall", 32'(stall_out), 32'd1);
        apply_stimulus(0, 1, I_ADD, 32'h230, 0, 1, 5'd3, 1, 0);
        check_output("lit_midrst_stall", 32'(stall_out), 32'd0);
        step();
        check_output("lit_midrst_pc", id_pc, RST_PC);
        apply_stimulus(1, 1, I_ADD, 32'h230, 0, 0, 5'd3, 0, 0);
        step();
        check_output("lit_after_rst_valid", 32'(id_valid), 32'd1);

        // Mixed traffic drawn from the directed instruction pool
        for (int k = 0; k < 80; k++) begin
            apply_stimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 5) != 0),
                           pool[$urandom_range(0, 9)], 32'h300 + 32'(k) * 4,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           5'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 7) == 0));
            step();
        end

        apply_stimulus(1, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
